object_pingpong_buffer: RTL
===========================

# object_pingpong_buffer

Double-banked successor to the single-bank object list, sitting between the object producer (scene/command decoder) and the rasteriser. The producer fills a back bank while the rasteriser streams the front bank, any number of times per frame; `next_frame` swaps banks atomically so a frame never mixes objects from two producer passes. Both ports use valid/ready handshakes, and write losses are reported per frame instead of silently stalling.

## Interface
Parameters:
- `SIZE`, 64: entries per bank; legal range ≥ 2. `CW = $clog2(SIZE+1)`.

Ports (`object_t` comes from package `common`):
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `next_frame` in 1: single-cycle pulse that swaps the banks.
- `wr_valid` in 1, `wr_data` in `object_t`, `wr_ready` out 1: producer port.
- `rd_valid` out 1, `rd_data` out `object_t`, `rd_ready` in 1, `rd_last` out 1: rasteriser port.
- `rd_rewind` in 1: restarts the front-bank read cursor at entry 0.
- `front_count` out CW: number of objects in the front bank.
- `back_count` out CW: number of objects written into the back bank so far.
- `frame_overflow` out 1: at least one write was dropped while filling the bank that is now front.
- `front_sel` out 1: index of the front bank (0 or 1).

## Operation
- Storage is two banks of `SIZE` `object_t` entries. Reads are combinational; writes are synchronous. Memory contents are not cleared by reset; counts gate visibility.
- Reset sets `front_sel`=0, both counts to 0, the read cursor to 0, the internal `overflow_q` to 0 and `frame_overflow` to 0. After reset: `rd_valid`=0, `rd_last`=0, `wr_ready`=1.
- Write port:
  - `wr_ready = (back_count != SIZE)`.
  - Accept (`wr_valid & wr_ready`): `back[back_count] <= wr_data` and `back_count++`.
  - Reject (`wr_valid & ~wr_ready`): data is dropped and `overflow_q` is set to 1.
- Read port:
  - `rd_valid = (cursor < front_count)`; `rd_data = front[cursor]`; `rd_last = rd_valid & (cursor == front_count-1)`.
  - Transfer (`rd_valid & rd_ready`): `cursor++`.
  - When the cursor reaches `front_count`, `rd_valid` drops until a rewind or a swap.
- `rd_rewind`: sets `cursor <= 0` and overrides any transfer in the same cycle. That transfer still counts as consumed by the rasteriser.
- `next_frame` swap, all in one edge:
  - `front_sel <= ~front_sel`.
  - `front_count <= back_count + (write accepted this cycle)`. A write accepted in the swap cycle lands in the old back bank and becomes visible in the new front bank.
  - `back_count <= 0`; `cursor <= 0`.
  - `frame_overflow <= overflow_q | (write rejected this cycle)`; `overflow_q <= 0`.
  - The old front bank becomes the new back bank and is overwritten from entry 0.
- Priority: `reset` > `next_frame` > `rd_rewind` > transfer. Write acceptance is evaluated every cycle, independent of read activity.
- `wr_ready` does not depend on `wr_valid`. `rd_valid` does not depend on `rd_ready`. Neither port has a combinational path to the other.

## Timing
- Write-to-read latency: an object accepted in frame N is readable starting the first cycle after the `next_frame` edge that ends frame N.
- `rd_data` and `rd_last` change the cycle after a transfer, since they follow the cursor.
- Back-to-back transfers are supported at 1 object per cycle on each port.
- `front_count`, `back_count` and `frame_overflow` are registered outputs that update on the edge.
- `next_frame` held high for k cycles gives k swaps; the producer guarantees single-cycle pulses.
- With an empty back bank, a swap gives `front_count`=0 and `rd_valid`=0 for the whole frame.
- Full bank: `back_count`=`SIZE`, `wr_ready`=0. This is the only state in which `back_count`=`SIZE`.

## Test plan
- Reset, then write 3 objects with `wr_valid` held high, then pulse `next_frame` → `front_count`=3, `rd_valid`=1. Three transfers yield entries 0, 1, 2 in order, `rd_last`=1 on the third only, then `rd_valid`=0.
- Streaming overlap: while front holds 3 objects and is being read, write 5 new objects, then swap → the reader sees the original 3 unchanged before the swap, and exactly the 5 new objects after it; `front_sel` toggles.
- Overflow (`SIZE`=4): offer 6 writes, then swap → 4 accepted, `wr_ready`=0 after the 4th, `frame_overflow`=1, `front_count`=4. The next swap with no rejected writes gives `frame_overflow`=0.
- Simultaneous events in one cycle: an accepted write plus `next_frame` → that object appears as the last entry of the new front bank. `rd_rewind` plus a transfer → cursor=0. `reset` plus `next_frame` → reset values.
- Rewind: read 2 of 4 objects, assert `rd_rewind` → `rd_data` is entry 0 the next cycle. Four further transfers return entries 0 through 3.
- Mid-operation reset, with the front bank partly read and the back bank half full: assert `reset` → next cycle `rd_valid`=0, both counts 0, `front_sel`=0, `wr_ready`=1.

Source files
------------

// File: rtl/object_pingpong_buffer.sv
// Double-banked object store: the producer fills the back bank while the rasteriser
// streams the front bank; next_frame swaps them atomically and reports dropped writes.
package common;
  typedef struct packed {
    logic [7:0]  kind;
    logic [11:0] x;
    logic [11:0] y;
  } object_t;
endpackage

module object_pingpong_buffer
  import common::*;
#(
  parameter int unsigned SIZE = 64,
  localparam int unsigned CW = $clog2(SIZE + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          next_frame,
  input  logic          wr_valid,
  input  object_t       wr_data,
  output logic          wr_ready,
  output logic          rd_valid,
  output object_t       rd_data,
  input  logic          rd_ready,
  output logic          rd_last,
  input  logic          rd_rewind,
  output logic [CW-1:0] front_count,
  output logic [CW-1:0] back_count,
  output logic          frame_overflow,
  output logic          front_sel
);

  localparam int unsigned AW = $clog2(SIZE);

  object_t       mem_q [2][SIZE];
  logic          front_sel_q, front_sel_d;
  logic [CW-1:0] front_count_q, front_count_d;
  logic [CW-1:0] back_count_q, back_count_d;
  logic [CW-1:0] cursor_q, cursor_d;
  logic          overflow_q, overflow_d;
  logic          frame_overflow_q, frame_overflow_d;

  logic          wr_accept, wr_reject;
  logic          rd_xfer;
  logic [AW-1:0] rd_idx;

  assign wr_ready  = (back_count_q != CW'(SIZE));
  assign wr_accept = wr_valid & wr_ready;
  assign wr_reject = wr_valid & ~wr_ready;

  assign rd_valid = (cursor_q < front_count_q);
  assign rd_last  = rd_valid & (cursor_q == front_count_q - CW'(1));
  assign rd_xfer  = rd_valid & rd_ready;
  // Cursor may sit at SIZE once drained; keep the index in range regardless.
  assign rd_idx   = rd_valid ? cursor_q[AW-1:0] : '0;
  assign rd_data  = mem_q[front_sel_q][rd_idx];

  assign front_sel      = front_sel_q;
  assign front_count    = front_count_q;
  assign back_count     = back_count_q;
  assign frame_overflow = frame_overflow_q;

  always_comb begin
    front_sel_d      = front_sel_q;
    front_count_d    = front_count_q;
    back_count_d     = back_count_q + (wr_accept ? CW'(1) : CW'(0));
    cursor_d         = cursor_q;
    overflow_d       = overflow_q | wr_reject;
    frame_overflow_d = frame_overflow_q;

    if (next_frame) begin
      front_sel_d      = ~front_sel_q;
      // A write accepted this cycle still lands in the outgoing back bank.
      front_count_d    = back_count_q + (wr_accept ? CW'(1) : CW'(0));
      back_count_d     = '0;
      cursor_d         = '0;
      frame_overflow_d = overflow_q | wr_reject;
      overflow_d       = 1'b0;
    end else if (rd_rewind) begin
      cursor_d = '0;
    end else if (rd_xfer) begin
      cursor_d = cursor_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      front_sel_q      <= 1'b0;
      front_count_q    <= '0;
      back_count_q     <= '0;
      cursor_q         <= '0;
      overflow_q       <= 1'b0;
      frame_overflow_q <= 1'b0;
    end else begin
      front_sel_q      <= front_sel_d;
      front_count_q    <= front_count_d;
      back_count_q     <= back_count_d;
      cursor_q         <= cursor_d;
      overflow_q       <= overflow_d;
      frame_overflow_q <= frame_overflow_d;
    end
  end

  // Storage is deliberately not cleared by reset; the counts gate visibility.
  always_ff @(posedge clock) begin
    if (!reset && wr_accept) begin
      mem_q[~front_sel_q][back_count_q[AW-1:0]] <= wr_data;
    end
  end

endmodule
